ibus_line_bridge: RTL and testbench

Instruction-bus bridge between the fetch stage's `ibus_req`/`ibus_resp` port and the 64-bit memory request channel. It accepts one 32-bit instruction fetch at a time and answers with a single-cycle `addr_ok`+`data_ok` pulse. A one-entry, 8-byte line buffer lets the second instruction of an aligned doubleword return without a memory access. A jump flush discards any in-flight fetch so that no stale instruction reaches the fetch stage.

---
 rtl/ibus_line_bridge.sv | 134 +++++++++++++
 tb/tb_ibus_line_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_line_bridge.sv
// Instruction-bus bridge: one 32-bit fetch at a time onto a 64-bit memory read channel,
// with a single-line (8-byte) buffer and jump-flush cancellation of in-flight fetches.
module ibus_line_bridge #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        flush,
  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  input  logic        mreq_ready,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_data
);

  typedef enum logic [1:0] {StIdle, StMreq, StMwait, StResp} state_e;

  state_e      state_q, state_d;
  logic [63:2] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        buf_valid_q;
  logic [60:0] buf_tag_q;
  logic [63:0] buf_data_q;

  logic        buf_hit;
  logic        buf_fill;
  logic        take_resp;
  logic [31:0] buf_word;
  logic [31:0] mresp_word;

  // Byte offset within a word is irrelevant to a word fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq_addr[1:0];

  assign buf_hit    = BUF_EN && buf_valid_q && (buf_tag_q == ireq_addr[63:3]);
  assign buf_word   = ireq_addr[2] ? buf_data_q[63:32] : buf_data_q[31:0];
  assign mresp_word = req_addr_q[2] ? mresp_data[63:32] : mresp_data[31:0];

  // Next-state logic: accept, issue, wait, respond; flush marks the in-flight fetch as stale.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    discard_d   = discard_q;
    resp_data_d = resp_data_q;
    take_resp   = 1'b0;
    buf_fill    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ireq_valid && !flush) begin
          req_addr_d = ireq_addr[63:2];
          if (buf_hit) begin
            resp_data_d = buf_word;
            state_d     = StResp;
          end else begin
            state_d = StMreq;
          end
        end
      end
      StMreq: begin
        if (flush) discard_d = 1'b1;
        // A response arriving with the handshake is handled exactly as in StMwait.
        if (mreq_ready) begin
          if (mresp_valid) take_resp = 1'b1;
          else             state_d   = StMwait;
        end
      end
      StMwait: begin
        if (flush) discard_d = 1'b1;
        if (mresp_valid) take_resp = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (take_resp) begin
      // The line is valid for its address even if the fetch itself was cancelled.
      buf_fill = 1'b1;
      if (discard_q || flush) begin
        discard_d = 1'b0;
        state_d   = StIdle;
      end else begin
        resp_data_d = mresp_word;
        state_d     = StResp;
      end
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      discard_q   <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      discard_q   <= discard_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Line buffer, refilled by every completed memory read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (buf_fill) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= req_addr_q[63:3];
      buf_data_q  <= mresp_data;
    end
  end

  // Only the ok pulse sees flush combinationally, so a redirect kills a response in flight.
  assign iresp_addr_ok = (state_q == StResp) && !flush;
  assign iresp_data_ok = iresp_addr_ok;
  assign iresp_data    = resp_data_q;
  assign mreq_valid    = (state_q == StMreq);
  assign mreq_addr     = {req_addr_q[63:3], 3'b000};

endmodule

// File: tb/tb_ibus_line_bridge.sv
// Scoreboard bench for ibus_line_bridge: directed fetches push expected instructions,
// a monitor pops and checks them on each ok pulse, and a memory model serves reads.
module tb_ibus_line_bridge;

  localparam logic [31:0] K = 32'hCAFE_0000;

  logic        clk;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        flush;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic        mreq_ready;
  logic        mresp_valid;
  logic [63:0] mresp_data;

  int n_chk  = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int mreq_cnt  = 0;
  int stall_cyc = 0;
  int resp_lat  = 1;
  logic [63:0] last_mreq_addr = '0;
  logic [31:0] exp_q[$];

  ibus_line_bridge #(.BUF_EN(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .flush        (flush),
    .mreq_valid   (mreq_valid),
    .mreq_addr    (mreq_addr),
    .mreq_ready   (mreq_ready),
    .mresp_valid  (mresp_valid),
    .mresp_data   (mresp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents: line 0x8000_0000 holds two real instructions, others a tagged pattern.
  function automatic logic [63:0] mem_line(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    if (a == 64'h8000_0000) return 64'h0000_0013_0010_0093;
    return {(lo + 32'd4) ^ K, lo ^ K};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    return a[31:0] ^ K;
  endfunction

  // Monitor: every ok pulse must match the oldest expected instruction.
  initial begin
    logic prev_ok;
    logic [31:0] e;
    prev_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (iresp_addr_ok || iresp_data_ok) begin
        check("ok_pair", iresp_data_ok, iresp_addr_ok);
        check("pulse_len", prev_ok, 1'b0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: got data %h, expected no pulse", iresp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", iresp_data, e);
        end
        pulse_cnt++;
      end
      prev_ok = iresp_addr_ok;
    end
  end

  // Memory model: stalls ready by stall_cyc, returns data resp_lat cycles after ready.
  initial begin
    logic [63:0] a;
    bit abort;
    mreq_ready  = 1'b0;
    mresp_valid = 1'b0;
    mresp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (mreq_valid && !rst) begin
        a = mreq_addr;
        abort = 1'b0;
        for (int i = 0; i < stall_cyc; i++) begin
          @(posedge clk); #1;
          if (rst) begin
            abort = 1'b1;
            break;
          end
          check("mreq_hold_valid", mreq_valid, 1'b1);
          check("mreq_hold_addr", mreq_addr, a);
        end
        if (!abort) begin
          mreq_ready = 1'b1;
          mreq_cnt++;
          last_mreq_addr = a;
          if (resp_lat == 0) begin
            mresp_valid = 1'b1;
            mresp_data  = mem_line(a);
          end
          @(posedge clk); #1;
          mreq_ready  = 1'b0;
          mresp_valid = 1'b0;
          check("mreq_drop", mreq_valid, 1'b0);
          if (resp_lat > 0) begin
            repeat (resp_lat - 1) begin
              @(posedge clk); #1;
            end
            mresp_valid = 1'b1;
            mresp_data  = mem_line(a);
            @(posedge clk); #1;
            mresp_valid = 1'b0;
          end
        end
      end
    end
  end

  // One fetch: hold the request until the pulse, then check cycles from request to pulse.
  task automatic fetch(input logic [63:0] a, input logic [31:0] exp, input int exp_lat,
                       input string name);
    int k;
    exp_q.push_back(exp);
    ireq_addr  = a;
    ireq_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      if (iresp_addr_ok) break;
      k++;
    end while (k < 50);
    if (k >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no pulse in 50 cycles, expected latency %0d", name, exp_lat);
    end else begin
      check({name, "_latency"}, k, exp_lat);
    end
    @(posedge clk); #1;
    ireq_valid = 1'b0;
  endtask

  initial begin
    int m0;
    int p0;
    rst        = 1'b1;
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mreq_valid", mreq_valid, 1'b0);
    check("rst_mreq_addr", mreq_addr, 64'h0);
    check("rst_addr_ok", iresp_addr_ok, 1'b0);
    check("rst_data_ok", iresp_data_ok, 1'b0);
    check("rst_data", iresp_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss: ready at once, data one cycle later.
    stall_cyc = 0;
    resp_lat  = 1;
    m0 = mreq_cnt;
    fetch(64'h8000_0000, 32'h0010_0093, 3, "cold_miss");
    check("cold_mreq_addr", last_mreq_addr, 64'h8000_0000);
    check("cold_mreq_cnt", mreq_cnt, m0 + 1);

    // Upper word of the same line comes from the buffer.
    m0 = mreq_cnt;
    fetch(64'h8000_0004, 32'h0000_0013, 1, "hit");
    check("hit_no_mreq", mreq_cnt, m0);

    // Stalled memory: 3 cycles of ready low, data 2 cycles after ready.
    stall_cyc = 3;
    resp_lat  = 2;
    fetch(64'h8000_0008, exp_word(64'h8000_0008), 7, "stall");
    check("stall_mreq_addr", last_mreq_addr, 64'h8000_0008);

    // Data in the same cycle as ready; upper-word select on a miss.
    stall_cyc = 0;
    resp_lat  = 0;
    fetch(64'h8000_001C, exp_word(64'h8000_001C), 2, "same_cycle");
    check("same_cycle_mreq_addr", last_mreq_addr, 64'h8000_0018);

    // Flush in MWAIT: response swallowed, line still filled.
    resp_lat = 3;
    m0 = mreq_cnt;
    p0 = pulse_cnt;
    ireq_addr  = 64'h8000_0010;
    ireq_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush      = 1'b1;
    ireq_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("flush_mwait_no_pulse", pulse_cnt, p0);
    check("flush_mwait_mreq_cnt", mreq_cnt, m0 + 1);
    m0 = mreq_cnt;
    fetch(64'h8000_0014, exp_word(64'h8000_0014), 1, "after_flush_hit");
    check("after_flush_no_mreq", mreq_cnt, m0);

    // Flush coincident with a hit's pulse cycle.
    p0 = pulse_cnt;
    ireq_addr  = 64'h8000_0010;
    ireq_valid = 1'b1;
    @(posedge clk); #1;
    flush      = 1'b1;
    ireq_valid = 1'b0;
    @(negedge clk);
    check("flush_resp_addr_ok", iresp_addr_ok, 1'b0);
    check("flush_resp_data_ok", iresp_data_ok, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_resp_no_pulse", pulse_cnt, p0);
    fetch(64'h8000_0010, exp_word(64'h8000_0010), 1, "after_resp_flush");

    // Flush in IDLE blocks acceptance.
    m0 = mreq_cnt;
    p0 = pulse_cnt;
    ireq_addr  = 64'h8000_0040;
    ireq_valid = 1'b1;
    flush      = 1'b1;
    @(posedge clk); #1;
    ireq_valid = 1'b0;
    flush      = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("flush_idle_no_mreq", mreq_cnt, m0);
    check("flush_idle_no_pulse", pulse_cnt, p0);

    // Asynchronous reset while the request sits in MREQ.
    stall_cyc = 20;
    resp_lat  = 1;
    m0 = mreq_cnt;
    ireq_addr  = 64'h8000_0020;
    ireq_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_mreq_valid", mreq_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_mreq_valid", mreq_valid, 1'b0);
    check("async_rst_mreq_addr", mreq_addr, 64'h0);
    ireq_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("async_rst_no_handshake", mreq_cnt, m0);
    stall_cyc = 0;
    resp_lat  = 1;
    fetch(64'h8000_0014, exp_word(64'h8000_0014), 3, "post_rst_miss");
    check("post_rst_mreq_cnt", mreq_cnt, m0 + 1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
